// File: rtl/instr_fetch_queue_if.sv
// Handshake bundle between the fetch queue, instruction memory, the branch unit and the decoder.
// The master modport is the fetch queue side; slave is the surrounding environment.
interface instr_fetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        br_valid;
    logic [31:0] br_target;
    logic        ir_valid;
    logic [31:0] ir_out;
    logic [31:0] ir_pc;
    logic        ir_ready;

    modport master (
        output imem_req, imem_addr, ir_valid, ir_out, ir_pc,
        input  imem_ack, imem_rdata, br_valid, br_target, ir_ready
    );

    modport slave (
        input  imem_req, imem_addr, ir_valid, ir_out, ir_pc,
        output imem_ack, imem_rdata, br_valid, br_target, ir_ready
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: sequential word fetch with req/ack, prefetch FIFO and branch flush.
// Optional macro IFQ_PC_PLUS8_EN makes ir_pc report the head fetch address + 8.
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                  clk,
    input logic                  rst,
    instr_fetch_queue_if.master  bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        DROP  = 1'b1
    } state_t;

    state_t             state_r, state_s;
    logic [31:0]        fetch_pc_r, fetch_pc_s;
    logic [31:0]        addr_r, addr_s;
    logic               req_r, req_s;
    logic [CNT_W-1:0]   count_r, count_s;
    logic [PTR_W-1:0]   wr_ptr_r, wr_ptr_s;
    logic [PTR_W-1:0]   rd_ptr_r, rd_ptr_s;
    logic [31:0]        word_mem_r [DEPTH];
    logic [31:0]        pc_mem_r   [DEPTH];
    logic               xfer_s, pop_s, push_s, head_valid_s;
    logic [31:0]        br_pc_s, head_pc_s;

    // Next-state logic: fetch FSM, FIFO bookkeeping and the registered request for the next cycle.
    always_comb begin
        state_s    = state_r;
        fetch_pc_s = fetch_pc_r;
        push_s     = 1'b0;
        count_s    = count_r;
        wr_ptr_s   = wr_ptr_r;
        rd_ptr_s   = rd_ptr_r;
        req_s      = 1'b0;
        addr_s     = addr_r;

        xfer_s       = req_r & bus.imem_ack;
        head_valid_s = (count_r != {CNT_W{1'b0}});
        pop_s        = head_valid_s & bus.ir_ready;
        br_pc_s      = bus.br_target & 32'hFFFF_FFFC;

        case (state_r)
            FETCH: begin
                if (bus.br_valid) begin
                    fetch_pc_s = br_pc_s;
                    if (req_r && !bus.imem_ack) begin
                        state_s = DROP;
                    end else begin
                        state_s = FETCH;
                    end
                end else begin
                    push_s = xfer_s;
                    if (xfer_s) begin
                        fetch_pc_s = fetch_pc_r + 32'd4;
                    end else begin
                        fetch_pc_s = fetch_pc_r;
                    end
                end
            end
            DROP: begin
                if (bus.br_valid) begin
                    fetch_pc_s = br_pc_s;
                end else begin
                    fetch_pc_s = fetch_pc_r;
                end
                if (xfer_s) begin
                    state_s = FETCH;
                end else begin
                    state_s = DROP;
                end
            end
            default: begin
                state_s = FETCH;
            end
        endcase

        // A redirect wins over any pop or push in the same cycle.
        if (bus.br_valid) begin
            count_s  = {CNT_W{1'b0}};
            wr_ptr_s = {PTR_W{1'b0}};
            rd_ptr_s = {PTR_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_s = wr_ptr_r + PTR_W'(1'b1);
            end else begin
                wr_ptr_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_s = rd_ptr_r + PTR_W'(1'b1);
            end else begin
                rd_ptr_s = rd_ptr_r;
            end
            count_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        end

        // While dropping, the stale address stays on the bus until its ack.
        if (state_s == DROP) begin
            req_s  = 1'b1;
            addr_s = addr_r;
        end else begin
            req_s  = (count_s < FULL_CNT);
            addr_s = fetch_pc_s;
        end
    end

    // Control and pointer registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= FETCH;
            fetch_pc_r <= RESET_PC;
            addr_r     <= RESET_PC;
            req_r      <= 1'b0;
            count_r    <= {CNT_W{1'b0}};
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
        end else begin
            state_r    <= state_s;
            fetch_pc_r <= fetch_pc_s;
            addr_r     <= addr_s;
            req_r      <= req_s;
            count_r    <= count_s;
            wr_ptr_r   <= wr_ptr_s;
            rd_ptr_r   <= rd_ptr_s;
        end
    end

    // FIFO storage; contents are only meaningful below count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            word_mem_r[wr_ptr_r] <= bus.imem_rdata;
            pc_mem_r[wr_ptr_r]   <= fetch_pc_r;
        end
    end

    // Head PC presented to the decoder.
    always_comb begin
`ifdef IFQ_PC_PLUS8_EN
        head_pc_s = pc_mem_r[rd_ptr_r] + 32'd8;
`else
        head_pc_s = pc_mem_r[rd_ptr_r];
`endif
    end

    assign bus.imem_req  = req_r;
    assign bus.imem_addr = addr_r;
    assign bus.ir_valid  = head_valid_s;
    assign bus.ir_out    = head_valid_s ? word_mem_r[rd_ptr_r] : 32'd0;
    assign bus.ir_pc     = head_valid_s ? head_pc_s : 32'd0;
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: directed vector table, hand sequences, and
// randomized traffic against a transaction-level queue model.
module tb_instr_fetch_queue;
    localparam int DEPTH = 4;
`ifdef IFQ_PC_PLUS8_EN
    localparam logic [31:0] PC_OFS = 32'd8;
`else
    localparam logic [31:0] PC_OFS = 32'd0;
`endif

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    instr_fetch_queue_if bus0 ();
    instr_fetch_queue_if bus1 ();

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ack;
        logic        br;
        logic [31:0] tgt;
        logic        ready;
        logic [31:0] rdata;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_out;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tbl [12];

    // Reference model state
    logic [63:0] mq [$];
    logic [31:0] m_fetch;
    logic [31:0] m_paddr;
    logic        m_pend;
    logic        m_drop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ack, input logic br, input logic [31:0] tgt,
                         input logic ready, input logic [31:0] rdata);
        bus0.imem_ack   = ack;
        bus0.br_valid   = br;
        bus0.br_target  = tgt;
        bus0.ir_ready   = ready;
        bus0.imem_rdata = rdata;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_req", {31'd0, bus0.imem_req}, 32'd0);
        chk("rst_addr", bus0.imem_addr, 32'd0);
        chk("rst_valid", {31'd0, bus0.ir_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic model_step(input logic ack, input logic br, input logic [31:0] tgt,
                              input logic ready, input logic [31:0] rdata);
        logic xfer;
        xfer = m_pend && ack;
        if (mq.size() != 0 && ready) void'(mq.pop_front());
        if (br) mq.delete();
        else if (xfer && !m_drop) mq.push_back({rdata, m_paddr});
        if (xfer) begin
            if (!m_drop) m_fetch = m_fetch + 32'd4;
            m_pend = 1'b0;
            m_drop = 1'b0;
        end
        if (br) begin
            m_fetch = tgt & 32'hFFFF_FFFC;
            if (m_pend) m_drop = 1'b1;
        end
        if (!m_pend && mq.size() < DEPTH) begin
            m_pend  = 1'b1;
            m_paddr = m_fetch;
        end
    endtask

    initial begin
        logic        r_ack, r_br, r_rdy;
        logic [31:0] r_tgt, r_rd;
        int          rdy_pct;

        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        bus1.imem_ack   = 1'b1;
        bus1.br_valid   = 1'b0;
        bus1.br_target  = 32'd0;
        bus1.ir_ready   = 1'b1;
        bus1.imem_rdata = 32'h1234_5678;

        //       ack   br    tgt            rdy   rdata          req   addr           vld   out            pc
        tbl[0]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000};
        tbl[1]  = '{1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'hE3A0_0001, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000};
        tbl[2]  = '{1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'hE3A0_0002, 1'b1, 32'h0000_0004, 1'b1, 32'hE3A0_0001, 32'h0000_0000};
        tbl[3]  = '{1'b1, 1'b1, 32'h0000_0203, 1'b1, 32'hDEAD_0008, 1'b1, 32'h0000_0008, 1'b1, 32'hE3A0_0002, 32'h0000_0004};
        tbl[4]  = '{1'b0, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0000, 1'b1, 32'h0000_0200, 1'b0, 32'h0000_0000, 32'h0000_0000};
        tbl[5]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 32'h0000_0200, 1'b0, 32'h0000_0000, 32'h0000_0000};
        tbl[6]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 32'h0000_0200, 1'b0, 32'h0000_0000, 32'h0000_0000};
        tbl[7]  = '{1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'hBAD0_0200, 1'b1, 32'h0000_0200, 1'b0, 32'h0000_0000, 32'h0000_0000};
        tbl[8]  = '{1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'hE1A0_0100, 1'b1, 32'h0000_0100, 1'b0, 32'h0000_0000, 32'h0000_0000};
        tbl[9]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0104, 1'b1, 32'hE1A0_0100, 32'h0000_0100};
        tbl[10] = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 32'h0000_0104, 1'b1, 32'hE1A0_0100, 32'h0000_0100};
        tbl[11] = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0104, 1'b0, 32'h0000_0000, 32'h0000_0000};

        // Address wrap from RESET_PC near the top of the address space
        do_reset();
        for (int i = 0; i < 4; i++) begin
            #1;
            if (i == 1) chk("wrap_addr0", bus1.imem_addr, 32'hFFFF_FFF8);
            if (i == 2) chk("wrap_addr1", bus1.imem_addr, 32'hFFFF_FFFC);
            if (i == 2) chk("wrap_pc", bus1.ir_pc, 32'hFFFF_FFF8 + PC_OFS);
            if (i == 3) chk("wrap_addr2", bus1.imem_addr, 32'h0000_0000);
            if (i != 0) chk("wrap_req", {31'd0, bus1.imem_req}, 32'd1);
            @(negedge clk);
        end

        // Directed table: sequential fetch, same-cycle redirect+ack, redirect during a delayed ack
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].ack, tbl[i].br, tbl[i].tgt, tbl[i].ready, tbl[i].rdata);
            #1;
            chk($sformatf("tbl%0d_req", i), {31'd0, bus0.imem_req}, {31'd0, tbl[i].exp_req});
            chk($sformatf("tbl%0d_addr", i), bus0.imem_addr, tbl[i].exp_addr);
            chk($sformatf("tbl%0d_valid", i), {31'd0, bus0.ir_valid}, {31'd0, tbl[i].exp_valid});
            chk($sformatf("tbl%0d_out", i), bus0.ir_out, tbl[i].exp_out);
            chk($sformatf("tbl%0d_pc", i), bus0.ir_pc,
                tbl[i].exp_valid ? tbl[i].exp_pc + PC_OFS : 32'd0);
            @(negedge clk);
        end

        // Fill the FIFO with the decoder stalled, then one pop re-opens fetch at 0x10
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive((i < 7) ? 1'b1 : 1'b0, 1'b0, 32'd0, (i == 6) ? 1'b1 : 1'b0, 32'hC0DE_0000 + i);
            #1;
            if (i >= 1 && i <= 4) begin
                chk("full_req_on", {31'd0, bus0.imem_req}, 32'd1);
                chk("full_addr_seq", bus0.imem_addr, (i - 1) * 4);
            end
            if (i == 5 || i == 6) begin
                chk("full_req_off", {31'd0, bus0.imem_req}, 32'd0);
                chk("full_addr_hold", bus0.imem_addr, 32'h0000_0010);
                chk("full_head", bus0.ir_out, 32'hC0DE_0001);
            end
            if (i == 7 || i == 8) begin
                chk("refill_req", {31'd0, bus0.imem_req}, 32'd1);
                chk("refill_addr", bus0.imem_addr, 32'h0000_0010);
                chk("refill_head", bus0.ir_out, 32'hC0DE_0002);
                chk("refill_pc", bus0.ir_pc, 32'h0000_0004 + PC_OFS);
            end
            @(negedge clk);
        end

        // Asynchronous reset with a request outstanding; an ack during reset is ignored
        #2;
        rst = 1'b1;
        bus0.imem_ack = 1'b1;
        #1;
        chk("arst_req", {31'd0, bus0.imem_req}, 32'd0);
        chk("arst_addr", bus0.imem_addr, 32'd0);
        chk("arst_valid", {31'd0, bus0.ir_valid}, 32'd0);
        chk("arst_out", bus0.ir_out, 32'd0);
        chk("arst_pc", bus0.ir_pc, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus0.imem_ack = 1'b0;
        #1;
        chk("arst_rel_valid", {31'd0, bus0.ir_valid}, 32'd0);
        @(negedge clk);
        #1;
        chk("arst_rel_req", {31'd0, bus0.imem_req}, 32'd1);
        chk("arst_rel_addr", bus0.imem_addr, 32'd0);
        chk("arst_rel_empty", {31'd0, bus0.ir_valid}, 32'd0);
        @(negedge clk);

        // Randomized traffic against the queue model
        do_reset();
        mq.delete();
        m_fetch = 32'd0;
        m_paddr = 32'd0;
        m_pend  = 1'b0;
        m_drop  = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            chk("rnd_req", {31'd0, bus0.imem_req}, {31'd0, m_pend});
            chk("rnd_addr", bus0.imem_addr, m_pend ? m_paddr : m_fetch);
            chk("rnd_valid", {31'd0, bus0.ir_valid}, (mq.size() != 0) ? 32'd1 : 32'd0);
            chk("rnd_out", bus0.ir_out, (mq.size() != 0) ? mq[0][63:32] : 32'd0);
            chk("rnd_pc", bus0.ir_pc, (mq.size() != 0) ? mq[0][31:0] + PC_OFS : 32'd0);
            rdy_pct = ((n / 500) % 3 == 0) ? 80 : (((n / 500) % 3 == 1) ? 15 : 50);
            r_ack = ($urandom_range(0, 1) == 1);
            r_br  = ($urandom_range(0, 11) == 0);
            r_tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
            r_rdy = ($urandom_range(0, 99) < rdy_pct);
            r_rd  = $urandom;
            drive(r_ack, r_br, r_tgt, r_rdy, r_rd);
            @(posedge clk);
            model_step(r_ack, r_br, r_tgt, r_rdy, r_rd);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Fetch stage directly upstream of the ARM instruction decoder.
- Generates sequential word fetch addresses and runs a req/ack handshake to instruction memory.
- Buffers returned words in a small prefetch FIFO and presents the head word plus its PC to the decoder with a valid/ready handshake.
- Branch redirects flush the FIFO and discard any in-flight stale fetch.

Parameters:
- DEPTH, 4: FIFO entries; power of two, 2..16.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-high.
- imem_req  out  1  fetch request, held until acked.
- imem_addr  out  32  fetch address, word-aligned; stable while imem_req=1 and not yet acked.
- imem_ack  in  1  transfer completes in a cycle where imem_req=1 and imem_ack=1.
- imem_rdata  in  32  instruction word, valid in the ack cycle.
- br_valid  in  1  redirect request from execute, single-cycle pulse.
- br_target  in  32  redirect address; bits [1:0] are ignored and forced to 0.
- ir_valid  out  1  FIFO non-empty (head valid).
- ir_out  out  32  head instruction word, to the decoder instruction input.
- ir_pc  out  32  fetch address of the head word.
- ir_ready  in  1  decoder accepts the head; pop when ir_valid and ir_ready.

Behaviour:
- Reset values: imem_req=0, imem_addr=RESET_PC, ir_valid=0, ir_out=0, ir_pc=0, FIFO count=0, fetch_pc=RESET_PC, state=FETCH.
- Reset asserted mid-transfer aborts immediately. Any ack arriving while rst=1 is ignored.
- FSM states:
  - FETCH: imem_req=1 when count<DEPTH, else 0. imem_addr=fetch_pc.
    - On ack: push {imem_rdata, fetch_pc}; fetch_pc += 4 (wraps modulo 2^32).
    - On br_valid: see redirect rules below.
  - DROP: a redirect arrived while a request was outstanding and unacked. imem_req stays 1 and imem_addr keeps the old address. On ack, rdata is discarded and the state returns to FETCH. imem_addr switches to the new fetch_pc in the cycle after the ack.
- At most one outstanding request. A request is only started when count<DEPTH, so pushes never overflow. Pops during a pending request only lower count.
- Latency: ack in cycle N gives ir_valid=1 in cycle N+1 (registered push). The earliest next request is in cycle N+1.
- FIFO behaviour:
  - Push and pop in the same cycle leaves count unchanged.
  - Pop when empty is impossible (gated by ir_valid).
  - Read and write pointers wrap modulo DEPTH.
  - ir_out and ir_pc are taken combinationally from the head entry. Both read 0 when empty.
- Redirect (br_valid=1), with priority over everything else:
  - FIFO is flushed: count=0 and pointers reset next cycle, so ir_valid=0 in cycle +1.
  - fetch_pc <= {br_target[31:2], 2'b00}.
  - If a request is pending and not acked in this cycle, go to DROP.
  - If ack occurs in the same cycle as br_valid, the acked word is discarded, there is no DROP, and the state stays FETCH.
  - If pop occurs in the same cycle as br_valid, the decoder still consumed the head; flush applies after.
  - br_valid while already in DROP: update fetch_pc to the newest target and remain in DROP.

Optional Feature:
- Macro IFQ_PC_PLUS8_EN.
- Defined: ir_pc = stored fetch address + 8 (modulo 2^32), giving the architectural PC-read value for the decoder/execute path.
- Undefined: ir_pc = the raw fetch address of the head word.
- No other behaviour changes.

Test Plan:
- Reset release, memory always acks, ir_ready=1 → imem_addr sequence 0x0, 0x4, 0x8. First ir_valid is one cycle after the first ack, with ir_out=rdata and ir_pc=0x0 (0x8 with IFQ_PC_PLUS8_EN).
- ir_ready=0, DEPTH=4, always-ack memory → exactly 4 pushes, then imem_req=0 with count=4. One pop re-enables imem_req next cycle at addr 0x10.
- Memory delays ack 3 cycles; br_valid with target 0x100 issued in the 1st wait cycle → imem_addr held at the old address until ack. Old word never appears. The next request goes to 0x100.
- br_valid with target 0x203 in the same cycle as ack of addr 0x8 → that word is dropped, ir_valid=0 next cycle, and the next request goes to 0x200 with no DROP state.
- Start at RESET_PC=32'hFFFF_FFF8, always-ack → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000 (wrap).
- rst asserted while imem_req=1 and unacked → all outputs return to reset values asynchronously, and the FIFO is empty after release.
